ysyx_23060201_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the single physical-memory read/write port.
- Masters are the fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Serializes their valid/ready requests onto one memory request/response channel that may stall for any number of cycles.
- Routes each response back to the master that issued it.
- Only one transaction is in flight at a time.

---
 rtl/ysyx_23060201_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_ysyx_23060201_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter for a single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; the default is fixed LSU-over-IFU priority.
module ysyx_23060201_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q;
    logic                    owner_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_wen_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [MASK_WIDTH-1:0]   mem_wmask_q;
    logic                    mem_req_valid_q;
    logic                    ifu_resp_valid_q;
    logic                    lsu_resp_valid_q;
    logic [DATA_WIDTH-1:0]   ifu_rdata_q;
    logic [DATA_WIDTH-1:0]   lsu_rdata_q;
    logic                    grant_lsu;
    logic                    grant_ifu;
`ifdef ARB_ROUND_ROBIN_EN
    logic                    last_owner_q;
`endif

    always_comb begin
        grant_lsu = lsu_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the master that did not win last time goes first.
        if (lsu_req_valid && ifu_req_valid) begin
            grant_lsu = ~last_owner_q;
        end
`endif
        grant_ifu = ifu_req_valid & ~grant_lsu;
    end

    // Readies are masked by rst so every output reads 0 while reset is held.
    assign ifu_req_ready  = (state_q == IDLE) & grant_ifu & ~rst;
    assign lsu_req_ready  = (state_q == IDLE) & grant_lsu & ~rst;
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wmask      = mem_wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= 1'b0;
            mem_addr_q       <= '0;
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= '0;
            mem_wmask_q      <= '0;
            mem_req_valid_q  <= 1'b0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_lsu) begin
                        owner_q         <= 1'b1;
                        mem_addr_q      <= lsu_addr;
                        mem_wen_q       <= lsu_wen;
                        mem_wdata_q     <= lsu_wdata;
                        mem_wmask_q     <= lsu_wen ? lsu_wmask : '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner_q    <= 1'b1;
`endif
                    end else if (grant_ifu) begin
                        owner_q         <= 1'b0;
                        mem_addr_q      <= ifu_addr;
                        mem_wen_q       <= 1'b0;
                        mem_wdata_q     <= '0;
                        mem_wmask_q     <= '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner_q    <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (owner_q) begin
                            // Stores complete without touching the load data register.
                            if (!mem_wen_q) begin
                                lsu_rdata_q <= mem_rdata;
                            end
                            lsu_resp_valid_q <= 1'b1;
                        end else begin
                            ifu_rdata_q      <= mem_rdata;
                            ifu_resp_valid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ifu_resp_valid_q <= 1'b0;
                    lsu_resp_valid_q <= 1'b0;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Self-checking bench for ysyx_23060201_mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ifu_v;  logic [31:0] ifu_a;
        logic        lsu_v;  logic [31:0] lsu_a; logic lsu_we; logic [31:0] lsu_wd; logic [3:0] lsu_wm;
        logic        mrdy;   logic mrv; logic [31:0] mrd;
        logic        e_ifu_rdy, e_lsu_rdy, e_mreqv;
        logic [31:0] e_maddr; logic e_mwen; logic [3:0] e_mwm;
        logic        e_ifu_rv, e_lsu_rv;
        logic [31:0] e_ifu_rd, e_lsu_rd;
    } vec_t;

    vec_t tbl [11];

    // Reference model: one transaction record plus progress flags.
    logic        m_busy, m_sent, m_done, m_owner, m_last_lsu, m_ifu_acc, m_lsu_acc;
    logic [31:0] m_addr, m_wdata, m_ifu_rd, m_lsu_rd;
    logic        m_wen;
    logic [3:0]  m_wmask;

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_done = 0; m_owner = 0; m_last_lsu = 0;
        m_ifu_acc = 0; m_lsu_acc = 0;
        m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0; m_ifu_rd = '0; m_lsu_rd = '0;
    endtask

    task automatic drive_idle();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic model_step();
        logic pick_lsu, pick_ifu;
`ifdef ARB_ROUND_ROBIN_EN
        pick_lsu = lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
`else
        pick_lsu = lsu_req_valid;
`endif
        pick_ifu = ifu_req_valid && !pick_lsu;
        chk("rnd ifu_req_ready", 32'(ifu_req_ready), 32'(!m_busy && pick_ifu));
        chk("rnd lsu_req_ready", 32'(lsu_req_ready), 32'(!m_busy && pick_lsu));
        chk("rnd mem_req_valid", 32'(mem_req_valid), 32'(m_busy && !m_sent));
        chk("rnd ifu_resp_valid", 32'(ifu_resp_valid), 32'(m_done && !m_owner));
        chk("rnd lsu_resp_valid", 32'(lsu_resp_valid), 32'(m_done && m_owner));
        chk("rnd ifu_rdata", ifu_rdata, m_ifu_rd);
        chk("rnd lsu_rdata", lsu_rdata, m_lsu_rd);
        chk("rnd mem_addr", mem_addr, m_addr);
        chk("rnd mem_wen", 32'(mem_wen), 32'(m_wen));
        chk("rnd mem_wmask", 32'(mem_wmask), 32'(m_wmask));
        if (m_wen) chk("rnd mem_wdata", mem_wdata, m_wdata);
        m_ifu_acc = 0;
        m_lsu_acc = 0;
        if (!m_busy) begin
            if (pick_lsu || pick_ifu) begin
                m_busy = 1; m_sent = 0; m_done = 0;
                m_owner = pick_lsu; m_last_lsu = pick_lsu;
                if (pick_lsu) begin
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata;
                    m_wmask = lsu_wen ? lsu_wmask : 4'h0;
                    m_lsu_acc = 1;
                end else begin
                    m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = 4'h0;
                    m_ifu_acc = 1;
                end
            end
        end else if (!m_sent) begin
            if (mem_req_ready) m_sent = 1;
        end else if (!m_done) begin
            if (mem_resp_valid) begin
                m_done = 1;
                if (!m_owner) m_ifu_rd = mem_rdata;
                else if (!m_wen) m_lsu_rd = mem_rdata;
            end
        end else begin
            m_busy = 0; m_sent = 0; m_done = 0;
        end
    endtask

    initial begin
        int pulses;
        int ngrant;
        logic [3:0] order, exp_order;

        //            ifu_v ifu_a         lsu_v lsu_a        we    wdata         wm    rdy   rv    rdata          irdy  lrdy  mrv   maddr         mwen  mwm   irv   lrv   ifu_rd        lsu_rd
        tbl[0]  = '{1'b1, 32'h80000000, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000413, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000413, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000413, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000413, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 4'h0, 1'b1, 1'b0, 32'h00000413, 32'h0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000413, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 32'h80000010, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h80000000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h80000010, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h80000010, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h80000010, 1'b0, 4'h0, 1'b0, 1'b1, 32'h00000413, 32'hCAFEF00D};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h80000010, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'hCAFEF00D};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h80000010, 1'b0, 4'h0, 1'b0, 1'b0, 32'h00000413, 32'hCAFEF00D};

        // Reset state
        drive_idle();
        rst = 1;
        @(negedge clk);
        chk("reset mem_req_valid", 32'(mem_req_valid), 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset resp_valids", 32'({ifu_resp_valid, lsu_resp_valid}), 32'h0);
        chk("reset rdata", ifu_rdata | lsu_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 0;

        // Vector table: IFU fetch, LSU load, spurious responses in IDLE
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            ifu_req_valid = tbl[i].ifu_v; ifu_addr = tbl[i].ifu_a;
            lsu_req_valid = tbl[i].lsu_v; lsu_addr = tbl[i].lsu_a; lsu_wen = tbl[i].lsu_we;
            lsu_wdata = tbl[i].lsu_wd; lsu_wmask = tbl[i].lsu_wm;
            mem_req_ready = tbl[i].mrdy; mem_resp_valid = tbl[i].mrv; mem_rdata = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("vec%0d ifu_req_ready", i), 32'(ifu_req_ready), 32'(tbl[i].e_ifu_rdy));
            chk($sformatf("vec%0d lsu_req_ready", i), 32'(lsu_req_ready), 32'(tbl[i].e_lsu_rdy));
            chk($sformatf("vec%0d mem_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].e_mreqv));
            chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("vec%0d mem_wen", i), 32'(mem_wen), 32'(tbl[i].e_mwen));
            chk($sformatf("vec%0d mem_wmask", i), 32'(mem_wmask), 32'(tbl[i].e_mwm));
            chk($sformatf("vec%0d ifu_resp_valid", i), 32'(ifu_resp_valid), 32'(tbl[i].e_ifu_rv));
            chk($sformatf("vec%0d lsu_resp_valid", i), 32'(lsu_resp_valid), 32'(tbl[i].e_lsu_rv));
            chk($sformatf("vec%0d ifu_rdata", i), ifu_rdata, tbl[i].e_ifu_rd);
            chk($sformatf("vec%0d lsu_rdata", i), lsu_rdata, tbl[i].e_lsu_rd);
        end

        // LSU store with a 5-cycle request stall
        @(posedge clk); #1;
        lsu_req_valid = 1; lsu_addr = 32'h80001000; lsu_wen = 1; lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF;
        mem_req_ready = 0; mem_resp_valid = 0;
        @(negedge clk);
        chk("store lsu_req_ready", 32'(lsu_req_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            @(negedge clk);
            chk("store stall mem_req_valid", 32'(mem_req_valid), 32'h1);
            chk("store stall mem_addr", mem_addr, 32'h80001000);
            chk("store stall mem_wen", 32'(mem_wen), 32'h1);
            chk("store stall mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("store stall mem_wmask", 32'(mem_wmask), 32'hF);
        end
        @(posedge clk); #1 mem_req_ready = 1;
        @(negedge clk);
        chk("store accept mem_req_valid", 32'(mem_req_valid), 32'h1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mem_req_ready = 0;
            mem_resp_valid = (i == 2);
            mem_rdata = 32'h55555555;
            @(negedge clk);
            if (lsu_resp_valid) pulses++;
            if (i == 3) chk("store resp pulse", 32'(lsu_resp_valid), 32'h1);
            chk("store ifu_resp_valid", 32'(ifu_resp_valid), 32'h0);
            chk("store lsu_rdata kept", lsu_rdata, 32'hCAFEF00D);
        end
        chk("store pulse count", 32'(pulses), 32'h1);

        // Simultaneous requests from reset
        do_reset();
        ngrant = 0;
        order = '0;
        @(posedge clk); #1;
        ifu_req_valid = 1; ifu_addr = 32'h80000100;
        lsu_req_valid = 1; lsu_addr = 32'h80000200; lsu_wen = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0BADF00D;
        for (int c = 0; c < 64 && ngrant < 4; c++) begin
            @(negedge clk);
            if (ifu_req_ready && lsu_req_ready) chk("both readies high", 32'h1, 32'h0);
`ifndef ARB_ROUND_ROBIN_EN
            chk("ifu_req_ready under lsu_req_valid", 32'(ifu_req_ready), 32'h0);
`endif
            if (lsu_req_ready || ifu_req_ready) begin
                order[ngrant] = lsu_req_ready;
                ngrant++;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        chk("grant count", 32'(ngrant), 32'd4);
        chk("grant order (bit i = LSU won i-th)", 32'(order), 32'(exp_order));

        // Reset mid-WAIT
        do_reset();
        @(posedge clk); #1;
        ifu_req_valid = 1; ifu_addr = 32'h80000300; mem_req_ready = 1; mem_resp_valid = 0;
        @(negedge clk);
        chk("rstwait accept", 32'(ifu_req_ready), 32'h1);
        @(posedge clk); #1 ifu_req_valid = 0;
        @(negedge clk);
        chk("rstwait req", 32'(mem_req_valid), 32'h1);
        @(posedge clk); #1;
        chk("rstwait addr before reset", mem_addr, 32'h80000300);
        chk("rstwait in WAIT", 32'(mem_req_valid), 32'h0);
        #2 rst = 1;
        #1;
        chk("rstwait async mem_addr", mem_addr, 32'h0);
        chk("rstwait async outputs", 32'({mem_req_valid, mem_wen, mem_wmask, ifu_resp_valid, lsu_resp_valid,
                                          ifu_req_ready, lsu_req_ready}), 32'h0);
        chk("rstwait async data", ifu_rdata | lsu_rdata | mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 0; mem_resp_valid = 1; mem_rdata = 32'hABCD0123;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstwait no resp pulse", 32'({ifu_resp_valid, lsu_resp_valid}), 32'h0);
            chk("rstwait no mem_req", 32'(mem_req_valid), 32'h0);
            chk("rstwait ifu_rdata", ifu_rdata, 32'h0);
            @(posedge clk); #1;
        end
        mem_resp_valid = 0; ifu_req_valid = 1;
        @(negedge clk);
        chk("rstwait idle accepts", 32'(ifu_req_ready), 32'h1);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!ifu_req_valid || m_ifu_acc) begin
                ifu_req_valid = ($urandom_range(0, 2) != 0);
                ifu_addr = $urandom;
            end
            if (!lsu_req_valid || m_lsu_acc) begin
                lsu_req_valid = ($urandom_range(0, 2) != 0);
                lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
                lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            end
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
